// File: rtl/majority_bit_sampler.sv
// 8N1-style serial receiver: 2-FF synchroniser, 3-sample majority vote per bit, byte out with noise/frame flags.
// Define PARITY_EN to add an even-parity bit after the data bits and drive parity_err.
module majority_bit_sampler #(
  parameter int CLKS_PER_SAMPLE = 54,
  parameter int OVERSAMPLE      = 16,
  parameter int DATA_BITS       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 noise_err,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int CW = $clog2(CLKS_PER_SAMPLE);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SAMPLE - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_CAP0   = SW'(M - 1);
  localparam logic [SW-1:0] S_CAP1   = SW'(M);
  localparam logic [SW-1:0] S_VOTE   = SW'(M + 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state, state_next;
  logic                   rx_meta, rx_s, rx_prev;
  logic [CW-1:0]          clk_cnt;
  logic [SW-1:0]          s, s_inc;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift;
  logic                   samp_a, samp_b;
  logic                   noise_acc;
  logic                   tick, active, vote_now, bit_end, v, noisy, start_go;

  // s counts ticks elapsed within the bit, so actions key on the post-increment value
  always_comb begin
    tick       = (clk_cnt == CLK_LAST);
    s_inc      = (s == S_LAST) ? '0 : s + 1'b1;
    active     = (state != IDLE);
    vote_now   = active && tick && (s_inc == S_VOTE);
    bit_end    = active && tick && (s == S_LAST);
    v          = (samp_a & samp_b) | (samp_b & rx_s) | (samp_a & rx_s);
    noisy      = !((samp_a == samp_b) && (samp_b == rx_s));
    start_go   = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_next = START;
          start_go   = 1'b1;
        end
      end
      START: begin
        if (vote_now && v) state_next = IDLE;
        else if (bit_end)  state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == BITS_ALL)) begin
`ifdef PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
      PARITY: begin
        if (bit_end) state_next = STOP;
      end
      STOP: begin
        if (vote_now) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

`ifdef PARITY_EN
  logic par_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      clk_cnt    <= '0;
      s          <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      noise_acc  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      noise_err  <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_EN
      par_err_q  <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta    <= rx_in;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      data_valid <= 1'b0;

      // Restart the tick phase at the detected edge so samples land on bit centres
      if (start_go) begin
        clk_cnt   <= '0;
        s         <= '0;
        noise_acc <= 1'b0;
      end else begin
        clk_cnt <= tick ? '0 : clk_cnt + 1'b1;
        if (active && tick) s <= s_inc;
        if (vote_now) noise_acc <= noise_acc | noisy;
      end

      if (active && tick && (s_inc == S_CAP0)) samp_a <= rx_s;
      if (active && tick && (s_inc == S_CAP1)) samp_b <= rx_s;

      case (state)
        START: begin
          if (bit_end) bit_cnt <= '0;
        end
        DATA: begin
          if (vote_now) begin
            shift   <= (shift >> 1) | (DATA_BITS'(v) << (DATA_BITS - 1));
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (vote_now) par_err_q <= v ^ (^shift);
        end
`endif
        STOP: begin
          if (vote_now) begin
            data_out   <= shift;
            noise_err  <= noise_acc | noisy;
            frame_err  <= !v;
            data_valid <= 1'b1;
`ifdef PARITY_EN
            parity_err <= par_err_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

`ifndef PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_majority_bit_sampler.sv
// Scoreboard bench for majority_bit_sampler: directed frames push hand-computed results; a monitor checks each data_valid.
module tb_majority_bit_sampler;

  localparam int CPS      = 4;
  localparam int OS       = 16;
  localparam int DB       = 8;
  localparam int M        = OS / 2;
  localparam int BIT_CLKS = CPS * OS;
`ifdef PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int LAT = 2 + ((1 + DB + P) * OS + M + 1) * CPS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_in = 1'b1;
  logic [DB-1:0] data_out;
  logic          data_valid, noise_err, frame_err, parity_err;

  typedef struct {
    logic [7:0] data;
    logic       noise;
    logic       frame;
    logic       parity;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  majority_bit_sampler #(
    .CLKS_PER_SAMPLE(CPS),
    .OVERSAMPLE     (OS),
    .DATA_BITS      (DB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .noise_err (noise_err),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] d, input logic n,
                               input logic f, input logic p, input logic dv);
    check({tag, "_data"},   32'(data_out),   32'(d));
    check({tag, "_noise"},  32'(noise_err),  32'(n));
    check({tag, "_frame"},  32'(frame_err),  32'(f));
    check({tag, "_parity"}, 32'(parity_err), 32'(p));
    check({tag, "_valid"},  32'(data_valid), 32'(dv));
  endtask

  // Glitch pulls the line low for one tick at the bit centre (middle sample only)
  task automatic send_bit(input logic b, input bit glitch);
    rx_in = b;
    if (glitch) begin
      repeat (M * CPS) @(negedge clk);
      rx_in = 1'b0;
      repeat (CPS) @(negedge clk);
      rx_in = b;
      repeat (BIT_CLKS - (M + 1) * CPS) @(negedge clk);
    end else begin
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int glitch_bit,
                            input logic par_bit, input logic [7:0] e_data,
                            input logic e_noise, input logic e_frame, input logic e_par);
    exp_t       e;
    logic [10:0] bits;
    bits     = {stop, par_bit, d, 1'b0};
    e.data   = e_data;
    e.noise  = e_noise;
    e.frame  = e_frame;
    e.parity = e_par;
    e.due    = cyc + 1 + LAT;
    sb.push_back(e);
    for (int i = 0; i <= DB; i++) send_bit(bits[i], (glitch_bit + 1) == i);
    if (P == 1) send_bit(bits[9], 1'b0);
    send_bit(bits[10], 1'b0);
    rx_in = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && data_valid === 1'b1) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got data_valid=1 at cycle %0d, expected no pulse", cyc);
        end else begin
          e = sb.pop_front();
          check("sb_data",   32'(data_out),   32'(e.data));
          check("sb_noise",  32'(noise_err),  32'(e.noise));
          check("sb_frame",  32'(frame_err),  32'(e.frame));
          check("sb_parity", 32'(parity_err), 32'(e.parity));
          tests++;
          if (cyc < e.due - 1 || cyc > e.due + 1) begin
            fails++;
            $display("FAIL sb_latency: got pulse at cycle %0d, expected %0d +-1", cyc, e.due);
          end
        end
      end
    end
  end

  initial begin : stim
    int wait_cnt;
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 1: clean frame
    send_frame(8'hA5, 1'b1, -1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    // 2: centre-sample glitch on data bit 2
    send_frame(8'h3C, 1'b1, 2, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);

    // 3: 5-tick low pulse is a false start
    rx_in = 1'b0;
    repeat (5 * CPS) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    check_outputs("false_start", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: stop bit low
    send_frame(8'h81, 1'b0, -1, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);

    // 5: reset in the middle of data bit 4, then a clean frame
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    rx_in = 1'b1;
    repeat (BIT_CLKS / 2) @(negedge clk);
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    check_outputs("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    send_frame(8'h5A, 1'b1, -1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

`ifdef PARITY_EN
    // 6: 0x07 has three ones, so even parity needs a 1
    send_frame(8'h07, 1'b1, -1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, -1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
`endif

    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 2000) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    repeat (200) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
